// File: rtl/dsconv_relu_sched.sv
// dsconv_relu_sched
// Frame scheduler for the ReLU stage behind the pointwise-conv accumulator.
// It accepts one IMG_H x IMG_W x CH frame of signed accumulator values under
// valid/ready flow control and tracks column/row/channel per pixel. Each pixel
// passes through a single registered ReLU stage that supports full
// backpressure.
// Optional build macro RELU_ZERO_CNT_EN adds a saturating 16-bit count of
// clamped (<= 0) pixels. When the macro is undefined, zero_cnt is tied to 0.
module dsconv_relu_sched #(
  parameter int DATA_W = 18,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int CH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(CH)-1:0]      out_ch,
  output logic                       out_last,
  output logic                       frame_done,
  output logic [15:0]                zero_cnt
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CH_W  = $clog2(CH);
  localparam int TOTAL = IMG_W * IMG_H * CH;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(CH - 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Frame bookkeeping: accepted-pixel count and position of the next pixel.
  logic [CNT_W-1:0] pix_cnt_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic [CH_W-1:0]  ch_cnt_reg;
  logic [COL_W-1:0] col_cnt_next;
  logic [ROW_W-1:0] row_cnt_next;
  logic [CH_W-1:0]  ch_cnt_next;

  // Output stage registers.
  logic                     out_valid_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic [COL_W-1:0]         out_col_reg;
  logic [ROW_W-1:0]         out_row_reg;
  logic [CH_W-1:0]          out_ch_reg;
  logic                     out_last_reg;

  logic start_accept;
  logic accept;
  logic last_accept;
  logic out_fire;
  logic positive;
  logic signed [DATA_W-1:0] relu_data;

  // Handshakes. in_ready depends only on state, the output register and
  // out_ready, never on in_valid.
  assign in_ready    = (state_reg == S_RUN) && (!out_valid_reg || out_ready);
  assign accept      = in_valid && in_ready;
  assign last_accept = (pix_cnt_reg == PIX_LAST);
  assign out_fire    = out_valid_reg && out_ready;

  // Treat the value as positive only when the sign bit is clear and the value
  // is non-zero. This keeps the test signed without relying on literal
  // signedness rules.
  assign positive  = !in_data[DATA_W-1] && (in_data != '0);
  assign relu_data = positive ? in_data : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the status outputs decoded from the state.
  always_comb begin
    state_next   = state_reg;
    busy         = 1'b0;
    frame_done   = 1'b0;
    start_accept = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (accept && last_accept) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_fire) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Position of the pixel following the current one. The channel saturates
  // at CH-1, so the final wrap of col/row does not overflow it.
  always_comb begin
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    ch_cnt_next  = ch_cnt_reg;
    if (col_cnt_reg == COL_MAX) begin
      col_cnt_next = '0;
      if (row_cnt_reg == ROW_MAX) begin
        row_cnt_next = '0;
        if (ch_cnt_reg != CH_MAX) begin
          ch_cnt_next = ch_cnt_reg + 1'b1;
        end
      end else begin
        row_cnt_next = row_cnt_reg + 1'b1;
      end
    end else begin
      col_cnt_next = col_cnt_reg + 1'b1;
    end
  end

  // Frame counters. They clear on an accepted start and advance on each
  // accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_reg <= '0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      ch_cnt_reg  <= '0;
    end else if (start_accept) begin
      pix_cnt_reg <= '0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      ch_cnt_reg  <= '0;
    end else if (accept) begin
      pix_cnt_reg <= pix_cnt_reg + 1'b1;
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
      ch_cnt_reg  <= ch_cnt_next;
    end
  end

  // Registered ReLU stage. Data and position load together on accept and
  // hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_col_reg   <= '0;
      out_row_reg   <= '0;
      out_ch_reg    <= '0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= relu_data;
      out_col_reg   <= col_cnt_reg;
      out_row_reg   <= row_cnt_reg;
      out_ch_reg    <= ch_cnt_reg;
      out_last_reg  <= (col_cnt_reg == COL_MAX) && (row_cnt_reg == ROW_MAX);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_col   = out_col_reg;
  assign out_row   = out_row_reg;
  assign out_ch    = out_ch_reg;
  assign out_last  = out_last_reg;

`ifdef RELU_ZERO_CNT_EN
  logic [15:0] zero_cnt_reg;

  // Clamped-pixel counter. It saturates at all-ones and clears when a new
  // frame starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_cnt_reg <= '0;
    end else if (start_accept) begin
      zero_cnt_reg <= '0;
    end else if (accept && !positive && (zero_cnt_reg != 16'hFFFF)) begin
      zero_cnt_reg <= zero_cnt_reg + 16'd1;
    end
  end

  assign zero_cnt = zero_cnt_reg;
`else
  assign zero_cnt = '0;
`endif

endmodule
